// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared defaults and width helper for the input conditioner
package input_conditioner_pkg;
  localparam int CLK_HZ              = 100_000_000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/input_conditioner_channel.sv
// conditioner_channel: synchroniser, debounce, edge pulses and toggle for one input bit
// Auto-repeat on held presses when INPUT_CONDITIONER_REPEAT_EN is defined.
module conditioner_channel
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = cnt_width(DEBOUNCE_CYCLES),
  parameter logic RESET_LEVEL     = 1'b0
`ifdef INPUT_CONDITIONER_REPEAT_EN
  , parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic toggle,
  output logic rise_next
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, toggle_q, toggle_d;
  logic s, accept, rep;
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], noisy};
    s        = sync_q[SYNC_STAGES-1];
    accept   = (s != clean_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    cnt_d    = (s == clean_q || accept) ? '0 : cnt_q + 1'b1;
    clean_d  = accept ? s : clean_q;
    rise_d   = (accept && s) || rep;
    fall_d   = accept && !s;
    toggle_d = toggle_q ^ (accept && s);
  end
`ifdef INPUT_CONDITIONER_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  logic [HOLD_W-1:0] hold_q, hold_d, hold_nx;
  // after each repeat the counter is rewound so the next one lands REPEAT_PERIOD later
  always_comb begin
    hold_nx = hold_q + 1'b1;
    rep     = clean_q && clean_d && (hold_nx == HOLD_W'(REPEAT_DELAY));
    hold_d  = !clean_q ? '0 : rep ? HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD) : hold_nx;
  end
  always_ff @(posedge clk)
    hold_q <= reset ? '0 : hold_d;
`else
  assign rep = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q    <= '0;
      clean_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end
  assign clean     = clean_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign toggle    = toggle_q;
  assign rise_next = rise_d;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: N_CH independent debounced inputs with edge pulses, toggle and any_rise
// Optional auto-repeat via INPUT_CONDITIONER_REPEAT_EN.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int              N_CH            = 8,
  parameter int              SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int              CNT_W           = cnt_width(DEBOUNCE_CYCLES),
  parameter logic [N_CH-1:0] RESET_LEVEL     = '0
`ifdef INPUT_CONDITIONER_REPEAT_EN
  , parameter int            REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int              REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] toggle,
  output logic            any_rise
);
  logic [N_CH-1:0] rise_next;
  logic any_rise_q, any_rise_d;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    conditioner_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_LEVEL    (RESET_LEVEL[i])
`ifdef INPUT_CONDITIONER_REPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .noisy    (noisy[i]),
      .clean    (clean[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .toggle   (toggle[i]),
      .rise_next(rise_next[i])
    );
  end
  always_comb any_rise_d = |rise_next;
  always_ff @(posedge clk)
    any_rise_q <= reset ? 1'b0 : any_rise_d;
  assign any_rise = any_rise_q;
endmodule
